// File: rtl/console_scroll_printer_pkg.sv
// Shared console definitions: character width and the printer state encoding.
package console_scroll_printer_pkg;

  localparam int CHAR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRINT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/console_line_ring.sv
// Ring of text rows: write lands on the oldest row and advances head,
// reads address rows logically relative to head.
module console_line_ring
  import console_scroll_printer_pkg::*;
#(
  parameter int LINES = 8,
  parameter int COLS  = 32,
  localparam int ROW_W = COLS * CHAR_W,
  localparam int PTR_W = $clog2(LINES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_row,
  output logic [ROW_W-1:0] rd_data
);

  logic [ROW_W-1:0] rows [LINES];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] rd_phys;

  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      for (int i = 0; i < LINES; i++) rows[i] <= '0;
    end else if (wr_en) begin
      rows[head] <= wr_data;
      head       <= head + 1'b1;
    end
  end

  // LINES is a power of two, so the pointer add wraps naturally
  assign rd_phys = head + rd_row;
  assign rd_data = rows[rd_phys];

endmodule

// File: rtl/console_scroll_printer.sv
// Scrolling text console that streams the leading columns of every row
// through a valid/ready character port; lines arriving mid-pass are deferred.
module console_scroll_printer
  import console_scroll_printer_pkg::*;
#(
  parameter int LINES      = 8,
  parameter int COLS       = 32,
  parameter int PRINT_COLS = 12,
  parameter int INDEX_W    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [COLS*CHAR_W-1:0] line_content,
  input  logic                   line_ready,
  input  logic                   start,
  input  logic                   char_ready,
  output logic                   char_valid,
  output logic [INDEX_W-1:0]     char_index,
  output logic [CHAR_W-1:0]      char_data,
  output logic                   busy,
  output logic                   finish,
  output logic                   overrun
);

  localparam int ROW_W = COLS * CHAR_W;
  localparam int PTR_W = $clog2(LINES);
  localparam int COL_W = $clog2(COLS) + 1;
  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(LINES - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(PRINT_COLS - 1);

  function automatic logic [CHAR_W-1:0] pick_char(input logic [ROW_W-1:0] row_bits,
                                                   input logic [COL_W-1:0] col);
    return CHAR_W'(row_bits >> ((COLS - 1 - int'(col)) * CHAR_W));
  endfunction

  function automatic logic [INDEX_W-1:0] screen_index(input logic [PTR_W-1:0] row,
                                                       input logic [COL_W-1:0] col);
    int lin;
    lin = int'(row) * COLS + int'(col);
    return INDEX_W'(lin);
  endfunction

  state_t           state, state_next;
  logic [PTR_W-1:0] row_cnt;
  logic [COL_W-1:0] col_cnt;
  logic             all_issued;
  logic             pending;
  logic [ROW_W-1:0] pend_line;
  logic             defer_line;
  logic             load_char, last_accept, ring_wr, ring_sel_pend;
  logic [ROW_W-1:0] ring_rd;

  console_line_ring #(
    .LINES(LINES),
    .COLS (COLS)
  ) u_ring (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (ring_wr),
    .wr_data(ring_sel_pend ? pend_line : line_content),
    .rd_row (row_cnt),
    .rd_data(ring_rd)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (pending) state_next = ST_COMMIT;
                 else if (start) state_next = ST_PRINT;
      ST_PRINT:  if (last_accept) state_next = pending ? ST_COMMIT : ST_IDLE;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    load_char     = 1'b0;
    last_accept   = 1'b0;
    ring_wr       = 1'b0;
    ring_sel_pend = 1'b0;
    case (state)
      ST_IDLE:   ring_wr = line_ready && !pending;
      ST_PRINT: begin
        load_char   = !all_issued && (!char_valid || char_ready);
        last_accept = all_issued && char_valid && char_ready;
      end
      ST_COMMIT: begin
        ring_wr       = 1'b1;
        ring_sel_pend = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // A leftover pending line in IDLE must be committed before any new one
  assign defer_line = line_ready && (state != ST_IDLE || pending);

  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (defer_line) begin
      pending <= 1'b1;
      if (pending && state != ST_COMMIT) overrun <= 1'b1;
    end else if (state == ST_COMMIT) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (defer_line) pend_line <= line_content;
  end

  // Output stage: one character register fed from the ring read port
  always_ff @(posedge clock) begin
    if (reset) begin
      row_cnt    <= '0;
      col_cnt    <= '0;
      all_issued <= 1'b0;
      char_valid <= 1'b0;
      char_index <= '0;
      char_data  <= '0;
      finish     <= 1'b0;
    end else begin
      finish <= last_accept;
      if (state != ST_PRINT) begin
        row_cnt    <= '0;
        col_cnt    <= '0;
        all_issued <= 1'b0;
      end else if (load_char) begin
        if (col_cnt == LAST_COL) begin
          col_cnt <= '0;
          if (row_cnt == LAST_ROW) all_issued <= 1'b1;
          else                     row_cnt    <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      if (load_char) begin
        char_valid <= 1'b1;
        char_index <= screen_index(row_cnt, col_cnt);
        char_data  <= pick_char(ring_rd, col_cnt);
      end else if (char_valid && char_ready) begin
        char_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_console_scroll_printer.sv
// Bench for console_scroll_printer: a row model builds the expected character
// stream per pass, which is popped and compared as the DUT hands characters out.
module tb_console_scroll_printer;

  localparam int LINES      = 8;
  localparam int COLS       = 32;
  localparam int PRINT_COLS = 12;
  localparam int INDEX_W    = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic [COLS*8-1:0]  line_content;
  logic               line_ready;
  logic               start;
  logic               char_ready;
  logic               char_valid;
  logic [INDEX_W-1:0] char_index;
  logic [7:0]         char_data;
  logic               busy;
  logic               finish;
  logic               overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mrow [LINES][COLS];
  int          mhead;
  logic [15:0] exp_q [$];
  logic [7:0]  got_r0, got_r7;

  console_scroll_printer #(
    .LINES(LINES), .COLS(COLS), .PRINT_COLS(PRINT_COLS), .INDEX_W(INDEX_W)
  ) dut (
    .clock(clock), .reset(reset), .line_content(line_content), .line_ready(line_ready),
    .start(start), .char_ready(char_ready), .char_valid(char_valid), .char_index(char_index),
    .char_data(char_data), .busy(busy), .finish(finish), .overrun(overrun)
  );

  always #5 clock = ~clock;

  function automatic logic [COLS*8-1:0] mk_line(input logic [7:0] c0);
    logic [COLS*8-1:0] v;
    for (int j = 0; j < COLS; j++) v[(COLS-1-j)*8 +: 8] = c0 + 8'(j);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++)
      for (int j = 0; j < COLS; j++) mrow[i][j] = 8'h00;
    mhead = 0;
  endtask

  task automatic model_commit(input logic [7:0] c0);
    for (int j = 0; j < COLS; j++) mrow[mhead][j] = c0 + 8'(j);
    mhead = (mhead + 1) % LINES;
  endtask

  task automatic build_expect();
    exp_q.delete();
    for (int r = 0; r < LINES; r++)
      for (int c = 0; c < PRINT_COLS; c++)
        exp_q.push_back({8'(r*COLS + c), mrow[(mhead + r) % LINES][c]});
  endtask

  task automatic push_line(input logic [7:0] c0);
    @(negedge clock);
    line_content = mk_line(c0);
    line_ready   = 1'b1;
    @(negedge clock);
    line_ready   = 1'b0;
    model_commit(c0);
  endtask

  task automatic run_pass(input bit with_line, input logic [7:0] line_c0,
                          input int stall_idx, input bit defer, input int abort_idx);
    int          naccept, stall_left, cyc;
    bit          stalled, done, fin_seen;
    logic [7:0]  h_idx, h_dat;
    logic [15:0] e;
    naccept = 0; stall_left = 3; cyc = 0;
    stalled = 0; done = 0; fin_seen = 0;
    got_r0 = 8'h00; got_r7 = 8'h00;
    @(negedge clock);
    start = 1'b1;
    if (with_line) begin
      line_content = mk_line(line_c0);
      line_ready   = 1'b1;
      model_commit(line_c0);
    end
    build_expect();
    while (!done) begin
      @(negedge clock);
      start = 1'b0; line_ready = 1'b0; cyc++;
      if (cyc == 1) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_pass: got %b want 1", busy); end
      end
      if (cyc > 400) begin
        n_checks++; n_fail++;
        $display("FAIL pass_timeout: %0d chars accepted, no finish within 400 cycles", naccept);
        done = 1;
      end else if (finish) begin
        fin_seen = 1; done = 1;
        n_checks++;
        if (char_valid !== 1'b0) begin
          n_fail++; $display("FAIL valid_at_finish: got %b want 0", char_valid);
        end
      end else begin
        if (stalled) begin
          n_checks++;
          if (char_valid !== 1'b1 || char_index !== h_idx || char_data !== h_dat) begin
            n_fail++;
            $display("FAIL hold: valid %b idx %0d data %h, want 1 idx %0d data %h",
                     char_valid, char_index, char_data, h_idx, h_dat);
          end
        end
        stalled = 0; char_ready = 1'b1;
        if (char_valid) begin
          if (abort_idx >= 0 && int'(char_index) == abort_idx) begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            n_checks++;
            if (finish !== 1'b0 || busy !== 1'b0 || char_valid !== 1'b0 || overrun !== 1'b0) begin
              n_fail++;
              $display("FAIL abort: finish %b busy %b valid %b overrun %b, want all 0",
                       finish, busy, char_valid, overrun);
            end
            model_clear(); exp_q.delete(); done = 1;
          end else if (stall_left > 0 && int'(char_index) == stall_idx) begin
            char_ready = 1'b0; stall_left--; stalled = 1;
            h_idx = char_index; h_dat = char_data;
          end else begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL extra_char: idx %0d data %h, want none", char_index, char_data);
            end else begin
              e = exp_q.pop_front();
              if (char_index !== e[15:8] || char_data !== e[7:0]) begin
                n_fail++;
                $display("FAIL char_%0d: idx %0d data %h, want idx %0d data %h",
                         naccept, char_index, char_data, e[15:8], e[7:0]);
              end
            end
            if (char_index == 8'd0)   got_r0 = char_data;
            if (char_index == 8'd224) got_r7 = char_data;
            naccept++;
            if (defer && naccept == 20) begin line_content = mk_line(8'h5A); line_ready = 1'b1; end
            if (defer && naccept == 30) begin line_content = mk_line(8'h59); line_ready = 1'b1; end
          end
        end
      end
    end
    char_ready = 1'b1;
    if (abort_idx < 0) begin
      n_checks++;
      if (!fin_seen) begin n_fail++; $display("FAIL finish_seen: got 0 want 1"); end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++; $display("FAIL missing_chars: %0d left, want 0", exp_q.size());
      end
      @(negedge clock);
      n_checks++;
      if (finish !== 1'b0) begin n_fail++; $display("FAIL finish_width: got %b want 0", finish); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; line_ready = 1'b0; char_ready = 1'b1; line_content = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({char_valid, char_index, char_data, busy, finish, overrun} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid %b idx %0d data %h busy %b finish %b overrun %b, want 0",
               char_valid, char_index, char_data, busy, finish, overrun);
    end
    model_clear();
    run_pass(0, 8'h00, -1, 0, -1);
  endtask

  task automatic test_scroll();
    for (int k = 0; k < 9; k++) push_line(8'h41 + 8'(k));
    run_pass(0, 8'h00, -1, 0, -1);
    n_checks++;
    if (got_r0 !== 8'h42) begin n_fail++; $display("FAIL scroll_row0: got %h want 42", got_r0); end
    n_checks++;
    if (got_r7 !== 8'h49) begin n_fail++; $display("FAIL scroll_row7: got %h want 49", got_r7); end
  endtask

  task automatic test_backpressure();
    run_pass(0, 8'h00, 33, 0, -1);
  endtask

  task automatic test_deferral();
    run_pass(0, 8'h00, -1, 1, -1);
    n_checks++;
    if (got_r7 !== 8'h49) begin n_fail++; $display("FAIL defer_unchanged: got %h want 49", got_r7); end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun: got %b want 1", overrun); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL commit_idle: busy %b want 0", busy); end
    model_commit(8'h59);
    run_pass(0, 8'h00, -1, 0, -1);
    n_checks++;
    if (got_r7 !== 8'h59) begin n_fail++; $display("FAIL commit_row7: got %h want 59", got_r7); end
  endtask

  task automatic test_simultaneous();
    run_pass(1, 8'h30, -1, 0, -1);
    n_checks++;
    if (got_r7 !== 8'h30) begin n_fail++; $display("FAIL simul_row7: got %h want 30", got_r7); end
  endtask

  task automatic test_reset_abort();
    run_pass(0, 8'h00, -1, 0, 100);
    @(negedge clock);
    n_checks++;
    if (finish !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_quiet: finish %b busy %b, want 0 0", finish, busy);
    end
    run_pass(0, 8'h00, -1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_backpressure();
    test_deferral();
    test_simultaneous();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/console_scroll_printer.md
CONSOLE_SCROLL_PRINTER -- requirements
Module: console_scroll_printer

Interface
REQ-001 SHALL have parameter LINES, default 8, number of stored text rows (power of two, >=2).
REQ-002 SHALL have parameter COLS, default 32, characters per row.
REQ-003 SHALL have parameter PRINT_COLS, default 12, leading columns per row streamed out (1..COLS).
REQ-004 SHALL have parameter INDEX_W, default 8, char_index width; LINES*COLS <= 2**INDEX_W.
REQ-005 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port line_content  input  COLS*8  new row; column 0 in the top byte, column COLS-1 in the bottom byte.
REQ-008 SHALL have port line_ready  input  1  one-cycle strobe qualifying line_content.
REQ-009 SHALL have port start  input  1  one-cycle strobe requesting a full print pass.
REQ-010 SHALL have port char_ready  input  1  downstream accepts the current character.
REQ-011 SHALL have port char_valid  output  1  char_index/char_data valid.
REQ-012 SHALL have port char_index  output  INDEX_W  screen position, row*COLS+col.
REQ-013 SHALL have port char_data  output  8  character code.
REQ-014 SHALL have port busy  output  1  high outside IDLE.
REQ-015 SHALL have port finish  output  1  one-cycle pulse at the end of a pass.
REQ-016 SHALL have port overrun  output  1  sticky; a deferred line was overwritten.

Function
REQ-017 SHALL store rows in a ring of LINES entries; head pointer = oldest row; logical row r maps to physical (head+r) mod LINES.
REQ-018 SHALL, on line_ready in IDLE, write line_content to physical row head and advance head by 1 (wrap), so the new line becomes logical row LINES-1 and every other row scrolls up one.
REQ-019 SHALL, on line_ready outside IDLE, latch line_content into a one-deep pending register; a second line_ready while pending is already set overwrites it and sets overrun.
REQ-020 SHALL implement states IDLE, PRINT, COMMIT.
REQ-021 SHALL go IDLE->PRINT on start; start outside IDLE SHALL be ignored; start and line_ready together in IDLE SHALL commit the line first (same cycle) and then print the scrolled contents.
REQ-022 SHALL, in PRINT, visit logical rows 0..LINES-1 and, within each row, columns 0..PRINT_COLS-1 in order, skipping columns >= PRINT_COLS with no idle cycles.
REQ-023 SHALL register outputs: char_valid rises the cycle after entry to PRINT; each char is held stable while char_valid && !char_ready; the next char appears the cycle after acceptance (one char per cycle when char_ready is held high).
REQ-024 SHALL, after the last char (row LINES-1, col PRINT_COLS-1) is accepted, drop char_valid, pulse finish for one cycle, and go to COMMIT if pending is set, else IDLE.
REQ-025 SHALL, in COMMIT, apply the pending line per REQ-018, clear pending, and return to IDLE in one cycle.
REQ-026 SHALL compute char_index as row*COLS+col truncated to INDEX_W; row and col are logical, not physical.
REQ-027 SHALL have char_data equal the byte of the row as it stood at start (row storage is not modified during PRINT).

Reset
REQ-028 SHALL, on reset, clear all rows to 8'h00, head to 0, pending and overrun to 0, char_valid/char_index/char_data/finish to 0, and state to IDLE.
REQ-029 SHALL, on reset during PRINT, abort without a finish pulse and discard the pending line.

Structure
REQ-030 SHALL place the state encoding and the character-byte width constant in the shared console package.
REQ-031 SHALL instantiate the ring storage as one sub-module, console_line_ring (write port, one combinational read port, head pointer).

Verification
REQ-032 SHALL test reset: every output 0; a pass prints 96 chars of 8'h00, indices 0..11, 32..43, ..., 224..235; finish pulses once.
REQ-033 SHALL test scrolling: push lines L0..L8 (char0 = 8'h41+k); a pass shows row0 char0 = 8'h42 (L1) and row7 char0 = 8'h49 (L8).
REQ-034 SHALL test backpressure: char_ready low for 3 cycles at index 33; char_valid/char_index/char_data stay constant; no char is skipped or duplicated.
REQ-035 SHALL test deferral: push line 8'h5A.. mid-pass, then push 8'h59..; the pass is unchanged, overrun=1, and after COMMIT row7 char0 = 8'h59.
REQ-036 SHALL test simultaneous start and line_ready in IDLE: the first printed row7 char equals the new line.
REQ-037 SHALL test reset at index 100: no finish pulse, busy=0 next cycle, all rows read 8'h00.
